ctrl_pipe: RTL and testbench

Parametrised pipelined control unit for the 5-stage MIPS core: decodes Op/Funct in Decode, carries control bits through the D/E, E/M and M/W control registers with stall/flush, and sequences a multi-cycle HI/LO multiply/divide unit. It extends the single-cycle decoder with jump, mult/div/mfhi/mflo support, a configurable ALU-control width and a hazard stall for mult/div.

---
 rtl/ctrl_pipe.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - pipelined MIPS control unit with D/E/M/W control registers and HI/LO mult/div sequencer
module ctrl_pipe #(
    parameter int ALUW   = 4,
    parameter int MD_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      op_d,
    input  logic [5:0]      funct_d,
    input  logic            flush_e,
    output logic            branch_d,
    output logic            bne_d,
    output logic            jump_d,
    output logic            extend_d,
    output logic            illegal_d,
    output logic            md_stall_d,
    output logic            regwrite_e,
    output logic            memtoreg_e,
    output logic            memwrite_e,
    output logic            alusrc_e,
    output logic            regdst_e,
    output logic [ALUW-1:0] alucontrol_e,
    output logic [1:0]      hilosel_e,
    output logic            md_start_e,
    output logic [1:0]      md_op_e,
    output logic            regwrite_m,
    output logic            memtoreg_m,
    output logic            memwrite_m,
    output logic            regwrite_w,
    output logic            memtoreg_w,
    output logic            md_busy,
    output logic            md_done
);

    localparam int CW = $clog2(MD_LAT);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    localparam logic [3:0] ALU_ADD  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b1110;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_LUI  = 4'b1101;
    localparam logic [3:0] ALU_SLLV = 4'b0001;
    localparam logic [3:0] ALU_SRAV = 4'b0011;
    localparam logic [3:0] ALU_SRLV = 4'b0101;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

    md_state_t     state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;

    logic            d_regwrite, d_memtoreg, d_memwrite, d_alusrc, d_regdst;
    logic [3:0]      d_alu4;
    logic [1:0]      d_hilosel;
    logic            d_md;
    logic [1:0]      d_mdop;
    logic            md_e;
    logic            bubble_e;

    // D-stage decode; every path starts from the all-zero bubble
    always_comb begin
        d_regwrite = 1'b0;
        d_memtoreg = 1'b0;
        d_memwrite = 1'b0;
        d_alusrc   = 1'b0;
        d_regdst   = 1'b0;
        d_alu4     = ALU_AND;
        d_hilosel  = 2'b00;
        d_md       = 1'b0;
        d_mdop     = 2'b00;
        branch_d   = 1'b0;
        bne_d      = 1'b0;
        jump_d     = 1'b0;
        extend_d   = 1'b0;
        illegal_d  = 1'b0;
        case (op_d)
            OP_RTYPE: begin
                d_regwrite = 1'b1;
                d_regdst   = 1'b1;
                extend_d   = 1'b1;
                case (funct_d)
                    F_ADD, F_ADDU: d_alu4 = ALU_ADD;
                    F_SUB:         d_alu4 = ALU_SUB;
                    F_AND:         d_alu4 = ALU_AND;
                    F_OR:          d_alu4 = ALU_OR;
                    F_XOR:         d_alu4 = ALU_XOR;
                    F_NOR:         d_alu4 = ALU_NOR;
                    F_SLT:         d_alu4 = ALU_SLT;
                    F_SLTU:        d_alu4 = ALU_SLTU;
                    F_SLLV:        d_alu4 = ALU_SLLV;
                    F_SRAV:        d_alu4 = ALU_SRAV;
                    F_SRLV:        d_alu4 = ALU_SRLV;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        d_regwrite = 1'b0;
                        d_regdst   = 1'b0;
                        d_md       = 1'b1;
                        d_mdop     = funct_d[1:0];
                    end
                    F_MFHI: d_hilosel = 2'b01;
                    F_MFLO: d_hilosel = 2'b10;
                    default: begin
                        d_regwrite = 1'b0;
                        d_regdst   = 1'b0;
                        extend_d   = 1'b0;
                        illegal_d  = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                d_regwrite = 1'b1;
                d_memtoreg = 1'b1;
                d_alusrc   = 1'b1;
                d_alu4     = ALU_ADD;
                extend_d   = 1'b1;
            end
            OP_SW: begin
                d_memwrite = 1'b1;
                d_alusrc   = 1'b1;
                d_alu4     = ALU_ADD;
                extend_d   = 1'b1;
            end
            OP_BEQ: begin
                branch_d = 1'b1;
                d_alu4   = ALU_SUB;
                extend_d = 1'b1;
            end
            OP_BNE: begin
                bne_d    = 1'b1;
                d_alu4   = ALU_SUB;
                extend_d = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                d_regwrite = 1'b1;
                d_alusrc   = 1'b1;
                d_alu4     = ALU_ADD;
                extend_d   = 1'b1;
            end
            OP_SLTI: begin
                d_regwrite = 1'b1;
                d_alusrc   = 1'b1;
                d_alu4     = ALU_SLT;
                extend_d   = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_SLTIU, OP_LUI: begin
                d_regwrite = 1'b1;
                d_alusrc   = 1'b1;
                case (op_d)
                    OP_ANDI:  d_alu4 = ALU_AND;
                    OP_ORI:   d_alu4 = ALU_OR;
                    OP_XORI:  d_alu4 = ALU_XOR;
                    OP_SLTIU: d_alu4 = ALU_SLTU;
                    default:  d_alu4 = ALU_LUI;
                endcase
            end
            OP_J: jump_d = 1'b1;
            default: illegal_d = 1'b1;
        endcase
    end

    // mfhi/mflo read HI/LO and mult/div overwrite them, so all four wait out a running sequence
    assign md_stall_d = md_busy & (d_md | (d_hilosel != 2'b00));
    assign bubble_e   = flush_e | md_stall_d;

    always_ff @(posedge clk) begin
        if (reset || bubble_e) begin
            regwrite_e   <= 1'b0;
            memtoreg_e   <= 1'b0;
            memwrite_e   <= 1'b0;
            alusrc_e     <= 1'b0;
            regdst_e     <= 1'b0;
            alucontrol_e <= '0;
            hilosel_e    <= 2'b00;
            md_e         <= 1'b0;
            md_op_e      <= 2'b00;
        end else begin
            regwrite_e   <= d_regwrite;
            memtoreg_e   <= d_memtoreg;
            memwrite_e   <= d_memwrite;
            alusrc_e     <= d_alusrc;
            regdst_e     <= d_regdst;
            alucontrol_e <= ALUW'(d_alu4);
            hilosel_e    <= d_hilosel;
            md_e         <= d_md;
            md_op_e      <= d_mdop;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regwrite_m <= 1'b0;
            memtoreg_m <= 1'b0;
            memwrite_m <= 1'b0;
            regwrite_w <= 1'b0;
            memtoreg_w <= 1'b0;
        end else begin
            regwrite_m <= regwrite_e;
            memtoreg_m <= memtoreg_e;
            memwrite_m <= memwrite_e;
            regwrite_w <= regwrite_m;
            memtoreg_w <= memtoreg_m;
        end
    end

    assign md_start_e = md_e & ~md_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            S_IDLE: begin
                if (md_start_e) begin
                    state_nx = S_BUSY;
                    cnt_nx   = CW'(MD_LAT - 1);
                end
            end
            S_BUSY: begin
                if (cnt == '0) state_nx = S_DONE;
                else           cnt_nx   = cnt - CW'(1);
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        md_busy = (state != S_IDLE);
        md_done = (state == S_DONE);
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - table-driven decode/pipeline checks plus mult/div sequencing corner cases
module tb_ctrl_pipe;

    logic       clk;
    logic       reset;
    logic [5:0] op_d, funct_d;
    logic       flush_e;
    logic       branch_d, bne_d, jump_d, extend_d, illegal_d, md_stall_d;
    logic       regwrite_e, memtoreg_e, memwrite_e, alusrc_e, regdst_e;
    logic [3:0] alucontrol_e;
    logic [1:0] hilosel_e, md_op_e;
    logic       md_start_e;
    logic       regwrite_m, memtoreg_m, memwrite_m, regwrite_w, memtoreg_w;
    logic       md_busy, md_done;

    int n_chk  = 0;
    int n_fail = 0;

    ctrl_pipe #(.ALUW(4), .MD_LAT(4)) dut (
        .clk(clk), .reset(reset), .op_d(op_d), .funct_d(funct_d), .flush_e(flush_e),
        .branch_d(branch_d), .bne_d(bne_d), .jump_d(jump_d), .extend_d(extend_d),
        .illegal_d(illegal_d), .md_stall_d(md_stall_d),
        .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e), .memwrite_e(memwrite_e),
        .alusrc_e(alusrc_e), .regdst_e(regdst_e), .alucontrol_e(alucontrol_e),
        .hilosel_e(hilosel_e), .md_start_e(md_start_e), .md_op_e(md_op_e),
        .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
        .regwrite_w(regwrite_w), .memtoreg_w(memtoreg_w),
        .md_busy(md_busy), .md_done(md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bits = {branch, bne, jump, extend, illegal, regwrite, memtoreg, memwrite, alusrc, regdst}
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [9:0] bits;
        logic [3:0] alu;
        logic [1:0] hs;
        logic       md;
        logic [1:0] mdop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [9:0] bits,
                                input logic [3:0] alu, input logic [1:0] hs, input logic md,
                                input logic [1:0] mdop);
        vec_t v;
        v.op = op; v.fn = fn; v.bits = bits; v.alu = alu; v.hs = hs; v.md = md; v.mdop = mdop;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && md_busy; k++) tick();
        chk("md_idle", {7'd0, md_busy}, 8'd0);
    endtask

    initial begin
        tbl.push_back(mk(6'b100011, 6'b000000, 10'b000_10_11010, 4'b0100, 2'b00, 1'b0, 2'b00)); // lw
        tbl.push_back(mk(6'b101011, 6'b000000, 10'b000_10_00110, 4'b0100, 2'b00, 1'b0, 2'b00)); // sw
        tbl.push_back(mk(6'b000100, 6'b000000, 10'b100_10_00000, 4'b1100, 2'b00, 1'b0, 2'b00)); // beq
        tbl.push_back(mk(6'b000101, 6'b000000, 10'b010_10_00000, 4'b1100, 2'b00, 1'b0, 2'b00)); // bne
        tbl.push_back(mk(6'b001000, 6'b000000, 10'b000_10_10010, 4'b0100, 2'b00, 1'b0, 2'b00)); // addi
        tbl.push_back(mk(6'b001001, 6'b000000, 10'b000_10_10010, 4'b0100, 2'b00, 1'b0, 2'b00)); // addiu
        tbl.push_back(mk(6'b001100, 6'b000000, 10'b000_00_10010, 4'b0000, 2'b00, 1'b0, 2'b00)); // andi
        tbl.push_back(mk(6'b001101, 6'b000000, 10'b000_00_10010, 4'b0010, 2'b00, 1'b0, 2'b00)); // ori
        tbl.push_back(mk(6'b001110, 6'b000000, 10'b000_00_10010, 4'b0110, 2'b00, 1'b0, 2'b00)); // xori
        tbl.push_back(mk(6'b001010, 6'b000000, 10'b000_10_10010, 4'b1110, 2'b00, 1'b0, 2'b00)); // slti
        tbl.push_back(mk(6'b001011, 6'b000000, 10'b000_00_10010, 4'b1000, 2'b00, 1'b0, 2'b00)); // sltiu
        tbl.push_back(mk(6'b001111, 6'b000000, 10'b000_00_10010, 4'b1101, 2'b00, 1'b0, 2'b00)); // lui
        tbl.push_back(mk(6'b000010, 6'b000000, 10'b001_00_00000, 4'b0000, 2'b00, 1'b0, 2'b00)); // j
        tbl.push_back(mk(6'b111111, 6'b000000, 10'b000_01_00000, 4'b0000, 2'b00, 1'b0, 2'b00)); // bad op
        tbl.push_back(mk(6'b000000, 6'b100000, 10'b000_10_10001, 4'b0100, 2'b00, 1'b0, 2'b00)); // add
        tbl.push_back(mk(6'b000000, 6'b100001, 10'b000_10_10001, 4'b0100, 2'b00, 1'b0, 2'b00)); // addu
        tbl.push_back(mk(6'b000000, 6'b100010, 10'b000_10_10001, 4'b1100, 2'b00, 1'b0, 2'b00)); // sub
        tbl.push_back(mk(6'b000000, 6'b100100, 10'b000_10_10001, 4'b0000, 2'b00, 1'b0, 2'b00)); // and
        tbl.push_back(mk(6'b000000, 6'b100101, 10'b000_10_10001, 4'b0010, 2'b00, 1'b0, 2'b00)); // or
        tbl.push_back(mk(6'b000000, 6'b100110, 10'b000_10_10001, 4'b0110, 2'b00, 1'b0, 2'b00)); // xor
        tbl.push_back(mk(6'b000000, 6'b100111, 10'b000_10_10001, 4'b1010, 2'b00, 1'b0, 2'b00)); // nor
        tbl.push_back(mk(6'b000000, 6'b101010, 10'b000_10_10001, 4'b1110, 2'b00, 1'b0, 2'b00)); // slt
        tbl.push_back(mk(6'b000000, 6'b101011, 10'b000_10_10001, 4'b1000, 2'b00, 1'b0, 2'b00)); // sltu
        tbl.push_back(mk(6'b000000, 6'b000100, 10'b000_10_10001, 4'b0001, 2'b00, 1'b0, 2'b00)); // sllv
        tbl.push_back(mk(6'b000000, 6'b000111, 10'b000_10_10001, 4'b0011, 2'b00, 1'b0, 2'b00)); // srav
        tbl.push_back(mk(6'b000000, 6'b000110, 10'b000_10_10001, 4'b0101, 2'b00, 1'b0, 2'b00)); // srlv
        tbl.push_back(mk(6'b000000, 6'b011000, 10'b000_10_00000, 4'b0000, 2'b00, 1'b1, 2'b00)); // mult
        tbl.push_back(mk(6'b000000, 6'b011001, 10'b000_10_00000, 4'b0000, 2'b00, 1'b1, 2'b01)); // multu
        tbl.push_back(mk(6'b000000, 6'b011010, 10'b000_10_00000, 4'b0000, 2'b00, 1'b1, 2'b10)); // div
        tbl.push_back(mk(6'b000000, 6'b011011, 10'b000_10_00000, 4'b0000, 2'b00, 1'b1, 2'b11)); // divu
        tbl.push_back(mk(6'b000000, 6'b010000, 10'b000_10_10001, 4'b0000, 2'b01, 1'b0, 2'b00)); // mfhi
        tbl.push_back(mk(6'b000000, 6'b010010, 10'b000_10_10001, 4'b0000, 2'b10, 1'b0, 2'b00)); // mflo
        tbl.push_back(mk(6'b000000, 6'b111111, 10'b000_01_00000, 4'b0000, 2'b00, 1'b0, 2'b00)); // bad funct

        // Reset held two cycles with lw in D
        reset = 1'b1; flush_e = 1'b0; op_d = 6'b100011; funct_d = 6'b000000;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_regwrite_e", {7'd0, regwrite_e}, 8'd0);
            chk("rst_memtoreg_e", {7'd0, memtoreg_e}, 8'd0);
            chk("rst_alucontrol_e", {4'd0, alucontrol_e}, 8'd0);
            chk("rst_regwrite_m", {7'd0, regwrite_m}, 8'd0);
            chk("rst_regwrite_w", {7'd0, regwrite_w}, 8'd0);
            chk("rst_md_busy", {7'd0, md_busy}, 8'd0);
            chk("rst_md_done", {7'd0, md_done}, 8'd0);
        end
        reset = 1'b0;
        tick();
        chk("lw_regwrite_e", {7'd0, regwrite_e}, 8'd1);
        chk("lw_memtoreg_e", {7'd0, memtoreg_e}, 8'd1);
        chk("lw_alusrc_e", {7'd0, alusrc_e}, 8'd1);
        chk("lw_alucontrol_e", {4'd0, alucontrol_e}, 8'h04);
        op_d = 6'b111111;
        tick();
        chk("lw_regwrite_m", {7'd0, regwrite_m}, 8'd1);
        chk("lw_memtoreg_m", {7'd0, memtoreg_m}, 8'd1);
        chk("bubble_regwrite_e", {7'd0, regwrite_e}, 8'd0);
        tick();
        chk("lw_regwrite_w", {7'd0, regwrite_w}, 8'd1);
        chk("lw_memtoreg_w", {7'd0, memtoreg_w}, 8'd1);
        tick();

        // Decode sweep: D outputs, then E, M, W
        foreach (tbl[i]) begin
            op_d = tbl[i].op; funct_d = tbl[i].fn;
            #1;
            chk($sformatf("v%0d_branch_d", i), {7'd0, branch_d}, {7'd0, tbl[i].bits[9]});
            chk($sformatf("v%0d_bne_d", i), {7'd0, bne_d}, {7'd0, tbl[i].bits[8]});
            chk($sformatf("v%0d_jump_d", i), {7'd0, jump_d}, {7'd0, tbl[i].bits[7]});
            chk($sformatf("v%0d_extend_d", i), {7'd0, extend_d}, {7'd0, tbl[i].bits[6]});
            chk($sformatf("v%0d_illegal_d", i), {7'd0, illegal_d}, {7'd0, tbl[i].bits[5]});
            chk($sformatf("v%0d_md_stall_d", i), {7'd0, md_stall_d}, 8'd0);
            tick();
            chk($sformatf("v%0d_regwrite_e", i), {7'd0, regwrite_e}, {7'd0, tbl[i].bits[4]});
            chk($sformatf("v%0d_memtoreg_e", i), {7'd0, memtoreg_e}, {7'd0, tbl[i].bits[3]});
            chk($sformatf("v%0d_memwrite_e", i), {7'd0, memwrite_e}, {7'd0, tbl[i].bits[2]});
            chk($sformatf("v%0d_alusrc_e", i), {7'd0, alusrc_e}, {7'd0, tbl[i].bits[1]});
            chk($sformatf("v%0d_regdst_e", i), {7'd0, regdst_e}, {7'd0, tbl[i].bits[0]});
            chk($sformatf("v%0d_alucontrol_e", i), {4'd0, alucontrol_e}, {4'd0, tbl[i].alu});
            chk($sformatf("v%0d_hilosel_e", i), {6'd0, hilosel_e}, {6'd0, tbl[i].hs});
            chk($sformatf("v%0d_md_start_e", i), {7'd0, md_start_e}, {7'd0, tbl[i].md});
            chk($sformatf("v%0d_md_op_e", i), {6'd0, md_op_e}, {6'd0, tbl[i].mdop});
            op_d = 6'b111111;
            tick();
            chk($sformatf("v%0d_regwrite_m", i), {7'd0, regwrite_m}, {7'd0, tbl[i].bits[4]});
            chk($sformatf("v%0d_memtoreg_m", i), {7'd0, memtoreg_m}, {7'd0, tbl[i].bits[3]});
            chk($sformatf("v%0d_memwrite_m", i), {7'd0, memwrite_m}, {7'd0, tbl[i].bits[2]});
            tick();
            chk($sformatf("v%0d_regwrite_w", i), {7'd0, regwrite_w}, {7'd0, tbl[i].bits[4]});
            chk($sformatf("v%0d_memtoreg_w", i), {7'd0, memtoreg_w}, {7'd0, tbl[i].bits[3]});
            wait_idle();
        end

        // mult with MD_LAT=4: start one cycle, busy five cycles, done in the fifth
        op_d = 6'b000000; funct_d = 6'b011000;
        tick();
        chk("mult_start", {7'd0, md_start_e}, 8'd1);
        chk("mult_busy0", {7'd0, md_busy}, 8'd0);
        op_d = 6'b111111;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("mult_busy%0d", k), {7'd0, md_busy}, 8'd1);
            chk($sformatf("mult_done%0d", k), {7'd0, md_done}, {7'd0, (k == 5)});
            chk($sformatf("mult_nostart%0d", k), {7'd0, md_start_e}, 8'd0);
        end
        tick();
        chk("mult_idle_busy", {7'd0, md_busy}, 8'd0);
        chk("mult_idle_done", {7'd0, md_done}, 8'd0);

        // mult, one unrelated op, then mflo stalls in D until the sequencer is idle
        op_d = 6'b000000; funct_d = 6'b011000;
        tick();
        op_d = 6'b001000;
        tick();
        op_d = 6'b000000; funct_d = 6'b010010;
        #1;
        chk("mflo_stall1", {7'd0, md_stall_d}, 8'd1);
        for (int k = 2; k <= 5; k++) begin
            if (k == 3) flush_e = 1'b1;
            tick();
            flush_e = 1'b0;
            chk($sformatf("mflo_stall%0d", k), {7'd0, md_stall_d}, 8'd1);
            chk($sformatf("mflo_bub_rw%0d", k), {7'd0, regwrite_e}, 8'd0);
            chk($sformatf("mflo_bub_hs%0d", k), {6'd0, hilosel_e}, 8'd0);
        end
        tick();
        chk("mflo_release_stall", {7'd0, md_stall_d}, 8'd0);
        chk("mflo_release_busy", {7'd0, md_busy}, 8'd0);
        chk("mflo_release_bub", {7'd0, regwrite_e}, 8'd0);
        tick();
        chk("mflo_hilosel_e", {6'd0, hilosel_e}, 8'd2);
        chk("mflo_regwrite_e", {7'd0, regwrite_e}, 8'd1);
        chk("mflo_regdst_e", {7'd0, regdst_e}, 8'd1);
        op_d = 6'b111111;
        tick();

        // beq and lw with flush_e: D decode unaffected, E gets a bubble
        op_d = 6'b000100; flush_e = 1'b1;
        #1;
        chk("beqf_branch_d", {7'd0, branch_d}, 8'd1);
        chk("beqf_bne_d", {7'd0, bne_d}, 8'd0);
        tick();
        chk("beqf_alucontrol_e", {4'd0, alucontrol_e}, 8'd0);
        op_d = 6'b100011;
        tick();
        chk("lwf_regwrite_e", {7'd0, regwrite_e}, 8'd0);
        chk("lwf_alusrc_e", {7'd0, alusrc_e}, 8'd0);
        flush_e = 1'b0; op_d = 6'b111111;
        tick();

        // reset in the middle of a running sequence: no done pulse afterwards
        op_d = 6'b000000; funct_d = 6'b011010;
        tick();
        op_d = 6'b111111;
        tick();
        tick();
        chk("rstmid_busy_before", {7'd0, md_busy}, 8'd1);
        reset = 1'b1;
        tick();
        chk("rstmid_busy", {7'd0, md_busy}, 8'd0);
        chk("rstmid_done", {7'd0, md_done}, 8'd0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rstmid_nodone%0d", k), {7'd0, md_done}, 8'd0);
            chk($sformatf("rstmid_nobusy%0d", k), {7'd0, md_busy}, 8'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
